// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic lamp safety monitor.
package traffic_pkg;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    FLASH   = 2'd2,
    RECOVER = 2'd3
  } mon_state_t;

  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_CONFLICT    = 3'd1;
  localparam logic [2:0] FC_MULTI_LAMP  = 3'd2;
  localparam logic [2:0] FC_DARK        = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL   = 3'd4;
  localparam logic [2:0] FC_SKIP_YELLOW = 3'd5;

  // One signal head, MSB first: {red, yellow, green}.
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED = 3'b100;
  localparam lamp_t LAMP_OFF = 3'b000;

  // Counter width able to hold 0..max_val, never narrower than 1 bit.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 2);
  endfunction

endpackage

// File: rtl/traffic_head_checker.sv
// Per-head lamp sanity checks: multi-lamp, dark timeout, short and skipped yellow.
// Flags are combinational on the sampled lamp plus this head's registered history.
module traffic_head_checker
  import traffic_pkg::*;
#(
  parameter int DARK_TOL   = 3,
  parameter int MIN_YELLOW = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  lamp_t lamp,
  output logic  multi,
  output logic  dark,
  output logic  short_yel,
  output logic  skip_yel
);

  localparam int DW = cnt_w(DARK_TOL);
  localparam int YW = cnt_w(MIN_YELLOW);

  lamp_t         prev;
  logic [DW-1:0] dark_cnt;   // consecutive all-dark cycles before this one
  logic [YW-1:0] yel_cnt;    // consecutive yellow cycles before this one
  logic          is_dark;

  assign is_dark   = (lamp == LAMP_OFF);
  assign multi     = (lamp.red & lamp.yellow) | (lamp.red & lamp.green) |
                     (lamp.yellow & lamp.green);
  assign dark      = is_dark && (dark_cnt >= DW'(DARK_TOL));
  assign short_yel = prev.yellow && !lamp.yellow && (yel_cnt < YW'(MIN_YELLOW));
  assign skip_yel  = prev.green && lamp.red && !lamp.green;

  // History and saturating run-length counters track the head every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= LAMP_OFF;
      dark_cnt <= '0;
      yel_cnt  <= '0;
    end else begin
      prev <= lamp;
      if (!is_dark)                      dark_cnt <= '0;
      else if (dark_cnt != DW'(DARK_TOL)) dark_cnt <= dark_cnt + 1'b1;
      if (!lamp.yellow)                     yel_cnt <= '0;
      else if (yel_cnt != YW'(MIN_YELLOW)) yel_cnt <= yel_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the light controller and lamp drivers. Passes lamps
// through with one cycle of latency, and on any unsafe pattern latches the
// first fault code and flashes both reds until cleared and proven healthy.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int CONFLICT_TOL   = 2,
  parameter int DARK_TOL       = 3,
  parameter int MIN_YELLOW     = 3,
  parameter int FLASH_HALF     = 5,
  parameter int STARTUP_CYCLES = 4,
  parameter int RECOVER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_red,
  input  logic       ns_yellow,
  input  logic       ns_green,
  input  logic       ew_red,
  input  logic       ew_yellow,
  input  logic       ew_green,
  input  logic       fault_clr,
  output logic       lamp_ns_red,
  output logic       lamp_ns_yellow,
  output logic       lamp_ns_green,
  output logic       lamp_ew_red,
  output logic       lamp_ew_yellow,
  output logic       lamp_ew_green,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int NUM_HEADS = 2;
  localparam int CFW  = cnt_w(CONFLICT_TOL);
  localparam int CMAX = (STARTUP_CYCLES > FLASH_HALF) ?
                        ((STARTUP_CYCLES > RECOVER_CYCLES) ? STARTUP_CYCLES : RECOVER_CYCLES) :
                        ((FLASH_HALF > RECOVER_CYCLES) ? FLASH_HALF : RECOVER_CYCLES);
  localparam int CW   = cnt_w(CMAX);

  logic [NUM_HEADS-1:0][2:0] head_in;
  logic [NUM_HEADS-1:0]      multi_v, dark_v, short_v, skip_v;

  assign head_in[0] = {ns_red, ns_yellow, ns_green};
  assign head_in[1] = {ew_red, ew_yellow, ew_green};

  for (genvar h = 0; h < NUM_HEADS; h++) begin : g_head
    traffic_head_checker #(
      .DARK_TOL   (DARK_TOL),
      .MIN_YELLOW (MIN_YELLOW)
    ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .lamp      (head_in[h]),
      .multi     (multi_v[h]),
      .dark      (dark_v[h]),
      .short_yel (short_v[h]),
      .skip_yel  (skip_v[h])
    );
  end

  mon_state_t     state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;        // startup / flash half-period / healthy-run timer
  logic           phase, phase_nxt;    // flashing-red phase
  logic [2:0]     code_nxt, fc_det;
  logic [CFW-1:0] conf_cnt;
  logic           both_nonred, conflict, any_fault;
  logic [5:0]     lamp_q, lamp_nxt;

  assign both_nonred = !ns_red && !ew_red;
  assign conflict    = both_nonred && (conf_cnt >= CFW'(CONFLICT_TOL));

  // Consecutive both-heads-off-red run length, saturating at the tolerance.
  always_ff @(posedge clk) begin
    if (rst || !both_nonred)               conf_cnt <= '0;
    else if (conf_cnt != CFW'(CONFLICT_TOL)) conf_cnt <= conf_cnt + 1'b1;
  end

  // Same-cycle faults resolve to the lowest code.
  always_comb begin
    fc_det = FC_NONE;
    if (conflict)        fc_det = FC_CONFLICT;
    else if (|multi_v)   fc_det = FC_MULTI_LAMP;
    else if (|dark_v)    fc_det = FC_DARK;
    else if (|short_v)   fc_det = FC_SHORT_YEL;
    else if (|skip_v)    fc_det = FC_SKIP_YELLOW;
  end
  assign any_fault = (fc_det != FC_NONE);

  // Next-state, timer, flash phase, fault code and next lamp image.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    code_nxt  = fault_code;
    case (state)
      STARTUP: begin
        if (cnt == CW'(STARTUP_CYCLES - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (any_fault) begin
          state_nxt = FLASH;
          code_nxt  = fc_det;
          cnt_nxt   = '0;
          phase_nxt = 1'b1;
        end
      end
      FLASH: begin
        if (fault_clr) begin
          state_nxt = RECOVER;
          cnt_nxt   = '0;
        end else if (cnt == CW'(FLASH_HALF - 1)) begin
          cnt_nxt   = '0;
          phase_nxt = !phase;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RECOVER: begin
        if (any_fault) begin
          state_nxt = FLASH;
          code_nxt  = fc_det;
          cnt_nxt   = '0;
          phase_nxt = 1'b1;
        end else if (cnt == CW'(RECOVER_CYCLES - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          code_nxt  = FC_NONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = STARTUP;
    endcase

    lamp_nxt = {LAMP_RED, LAMP_RED};
    case (state_nxt)
      RUN:     lamp_nxt = {head_in[0], head_in[1]};
      FLASH:   lamp_nxt = {phase_nxt, 2'b00, phase_nxt, 2'b00};
      default: lamp_nxt = {LAMP_RED, LAMP_RED};
    endcase
  end

  // State and registered driver outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STARTUP;
      cnt        <= '0;
      phase      <= 1'b0;
      fault_code <= FC_NONE;
      fault      <= 1'b0;
      lamp_q     <= {LAMP_RED, LAMP_RED};
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      phase      <= phase_nxt;
      fault_code <= code_nxt;
      fault      <= (state_nxt == FLASH) || (state_nxt == RECOVER);
      lamp_q     <= lamp_nxt;
    end
  end

  assign {lamp_ns_red, lamp_ns_yellow, lamp_ns_green,
          lamp_ew_red, lamp_ew_yellow, lamp_ew_green} = lamp_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed, table-driven bench for traffic_conflict_monitor.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] D  = 3'b000;
  localparam logic [2:0] YG = 3'b011;
  localparam logic [2:0] RG = 3'b101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ns_red = 1'b0, ns_yellow = 1'b0, ns_green = 1'b0;
  logic       ew_red = 1'b0, ew_yellow = 1'b0, ew_green = 1'b0;
  logic       fault_clr = 1'b0;
  logic       lamp_ns_red, lamp_ns_yellow, lamp_ns_green;
  logic       lamp_ew_red, lamp_ew_yellow, lamp_ew_green;
  logic       fault;
  logic [2:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_conflict_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .ns_red         (ns_red),
    .ns_yellow      (ns_yellow),
    .ns_green       (ns_green),
    .ew_red         (ew_red),
    .ew_yellow      (ew_yellow),
    .ew_green       (ew_green),
    .fault_clr      (fault_clr),
    .lamp_ns_red    (lamp_ns_red),
    .lamp_ns_yellow (lamp_ns_yellow),
    .lamp_ns_green  (lamp_ns_green),
    .lamp_ew_red    (lamp_ew_red),
    .lamp_ew_yellow (lamp_ew_yellow),
    .lamp_ew_green  (lamp_ew_green),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [5:0] lamps;
    logic       flt;
    logic [2:0] code;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic r, input logic c, input logic [2:0] ns, input logic [2:0] ew,
                   input logic [5:0] lamps, input logic f, input logic [2:0] code);
    vec_t e;
    e.rst = r; e.clr = c; e.ns = ns; e.ew = ew;
    e.lamps = lamps; e.flt = f; e.code = code;
    tbl.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge, let the rising edge take them.
  task automatic step(input logic r, input logic c, input logic [2:0] ns, input logic [2:0] ew);
    @(negedge clk);
    rst = r; fault_clr = c;
    {ns_red, ns_yellow, ns_green} = ns;
    {ew_red, ew_yellow, ew_green} = ew;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] lamps, input logic f,
                       input logic [2:0] code);
    logic [5:0] got;
    got = {lamp_ns_red, lamp_ns_yellow, lamp_ns_green,
           lamp_ew_red, lamp_ew_yellow, lamp_ew_green};
    n_checks++;
    if (got !== lamps || fault !== f || fault_code !== code) begin
      n_fail++;
      $display("FAIL %s: got lamps=%b fault=%b code=%0d, want lamps=%b fault=%b code=%0d",
               name, got, fault, fault_code, lamps, f, code);
    end
  endtask

  initial begin
    // reset + startup, normal cycle
    v(1,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {G,R},0,0);
    v(0,0,Y,R, {Y,R},0,0);
    v(0,0,Y,R, {Y,R},0,0);
    v(0,0,Y,R, {Y,R},0,0);
    v(0,0,R,R, {R,R},0,0);
    v(0,0,R,G, {R,G},0,0);
    v(0,0,R,G, {R,G},0,0);
    v(0,0,R,Y, {R,Y},0,0);
    v(0,0,R,Y, {R,Y},0,0);
    v(0,0,R,Y, {R,Y},0,0);
    v(0,0,R,R, {R,R},0,0);
    v(0,0,G,R, {G,R},0,0);
    // both off red for exactly CONFLICT_TOL cycles: tolerated
    v(0,0,G,D, {G,D},0,0);
    v(0,0,G,D, {G,D},0,0);
    v(0,0,G,R, {G,R},0,0);
    // both green for three cycles: conflict, then flash 5 on / 5 off
    v(0,0,G,G, {G,G},0,0);
    v(0,0,G,G, {G,G},0,0);
    v(0,0,G,G, {R,R},1,1);
    v(0,0,G,G, {R,R},1,1);
    v(0,0,G,G, {R,R},1,1);
    v(0,0,G,G, {R,R},1,1);
    v(0,0,RG,R,{R,R},1,1);
    v(0,0,RG,R,{D,D},1,1);
    v(0,0,RG,R,{D,D},1,1);
    v(0,0,RG,R,{D,D},1,1);
    v(0,0,R,R, {D,D},1,1);
    v(0,0,R,R, {D,D},1,1);
    v(0,0,R,R, {R,R},1,1);
    // clear -> RECOVER, 8 healthy cycles -> RUN; clear in RECOVER/RUN ignored
    v(0,1,R,R, {R,R},1,1);
    v(0,0,R,R, {R,R},1,1);
    v(0,1,R,R, {R,R},1,1);
    v(0,0,R,R, {R,R},1,1);
    v(0,0,R,R, {R,R},1,1);
    v(0,0,R,R, {R,R},1,1);
    v(0,0,R,R, {R,R},1,1);
    v(0,0,R,R, {R,R},1,1);
    v(0,0,G,R, {G,R},0,0);
    v(0,1,G,R, {G,R},0,0);
    // short yellow
    v(0,0,Y,R, {Y,R},0,0);
    v(0,0,Y,R, {Y,R},0,0);
    v(0,0,R,R, {R,R},1,4);
    // clear, then NS dark for 4 cycles mid-RECOVER
    v(0,1,R,R, {R,R},1,4);
    v(0,0,R,R, {R,R},1,4);
    v(0,0,R,R, {R,R},1,4);
    v(0,0,D,R, {R,R},1,4);
    v(0,0,D,R, {R,R},1,4);
    v(0,0,D,R, {R,R},1,4);
    v(0,0,D,R, {R,R},1,3);
    v(0,0,D,R, {R,R},1,3);
    // reset mid-FLASH, then skipped yellow
    v(1,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {G,R},0,0);
    v(0,0,R,R, {R,R},1,5);
    // EW dark 4 cycles
    v(1,0,R,R, {R,R},0,0);
    v(0,0,R,R, {R,R},0,0);
    v(0,0,R,R, {R,R},0,0);
    v(0,0,R,R, {R,R},0,0);
    v(0,0,R,G, {R,G},0,0);
    v(0,0,R,D, {R,D},0,0);
    v(0,0,R,D, {R,D},0,0);
    v(0,0,R,D, {R,D},0,0);
    v(0,0,R,D, {R,R},1,3);
    // multi-lamp in the same cycle as conflict timeout: conflict wins
    v(1,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {R,R},0,0);
    v(0,0,G,R, {G,R},0,0);
    v(0,0,G,G, {G,G},0,0);
    v(0,0,G,G, {G,G},0,0);
    v(0,0,YG,G,{R,R},1,1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].ns, tbl[i].ew);
      check($sformatf("row%0d", i), tbl[i].lamps, tbl[i].flt, tbl[i].code);
    end

    // Hand sequence: long yellow saturates the counter without a fault,
    // and exactly DARK_TOL dark cycles are tolerated.
    step(1,0,R,R); check("seq_rst", {R,R}, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0,0,R,R); check($sformatf("seq_startup%0d", k), {R,R}, 0, 0);
    end
    step(0,0,G,R); check("seq_run", {G,R}, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(0,0,Y,R); check($sformatf("seq_longyel%0d", k), {Y,R}, 0, 0);
    end
    step(0,0,R,R); check("seq_yel_end", {R,R}, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0,0,D,R); check($sformatf("seq_dark%0d", k), {D,R}, 0, 0);
    end
    step(0,0,R,R); check("seq_dark_end", {R,R}, 0, 0);
    // Flash entry by multi-lamp alone gives code 2.
    step(0,0,R,RG); check("seq_multi", {R,R}, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
